// File: rtl/spi_slave_regs.sv
// SPI slave terminating the 16-bit frame (5-bit command + 11 data bits, MSB first)
// in front of a 16 x 11-bit configuration register file; address 0 reads a fixed ID.
module spi_slave_regs #(
    parameter int                    CMD_WIDTH  = 5,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DATA_WIDTH = 11,
    parameter logic                  WRITE      = 1'b0,
    parameter logic                  READ       = 1'b1,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 11'h305
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  spi_cs_n,
    input  logic                  spi_sclk,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    output logic                  reg_wr_valid,
    output logic [ADDR_WIDTH-1:0] reg_wr_addr,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    output logic [DATA_WIDTH-1:0] cfg_rdata
);
    localparam int                CNT_W    = $clog2(CMD_WIDTH + DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_CMD = CNT_W'(CMD_WIDTH - 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(CMD_WIDTH + DATA_WIDTH - 1);
    localparam int                DEPTH    = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t                  state, state_nx;
    logic [2:0]              cs_q, sclk_q;
    logic [1:0]              mosi_q;
    logic                    cs_s, cs_fall, sclk_rise, sclk_fall, mosi_s;
    logic [CNT_W-1:0]        bit_cnt;
    logic [DATA_WIDTH-2:0]   sh;
    logic [DATA_WIDTH-1:0]   tx_shift;
    logic                    rw_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    miso_q, oe_q;
    logic [CMD_WIDTH-1:0]    cmd_word;
    logic [DATA_WIDTH-1:0]   rx_word;
    logic [DATA_WIDTH-1:0]   regs [DEPTH];

    // cs_n chain resets to "low" so a frame cut by reset is not restarted
    // until the master raises and drops cs_n again.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cs_q   <= '0;
            sclk_q <= '0;
            mosi_q <= '0;
        end else begin
            cs_q   <= {cs_q[1:0], spi_cs_n};
            sclk_q <= {sclk_q[1:0], spi_sclk};
            mosi_q <= {mosi_q[0], spi_mosi};
        end
    end

    assign cs_s      = cs_q[1];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign sclk_rise = sclk_q[1] & ~sclk_q[2] & ~cs_s;
    assign sclk_fall = ~sclk_q[1] & sclk_q[2] & ~cs_s;
    assign mosi_s    = mosi_q[1];
    assign cmd_word  = {sh[CMD_WIDTH-2:0], mosi_s};
    assign rx_word   = {sh, mosi_s};

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cs_fall) state_nx = CMD;
            CMD:     if (cs_s) state_nx = IDLE;
                     else if (sclk_fall && bit_cnt == LAST_CMD) state_nx = DATA;
            DATA:    if (cs_s) state_nx = IDLE;
                     else if (sclk_fall && bit_cnt == LAST_BIT) state_nx = DONE;
            DONE:    if (cs_s) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        spi_miso_oe = 1'b0;
        spi_miso    = 1'b0;
        if (state == DATA && rw_q == READ) begin
            spi_miso_oe = oe_q;
            spi_miso    = miso_q;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            bit_cnt      <= '0;
            sh           <= '0;
            tx_shift     <= '0;
            rw_q         <= WRITE;
            addr_q       <= '0;
            miso_q       <= 1'b0;
            oe_q         <= 1'b0;
            reg_wr_valid <= 1'b0;
            reg_wr_addr  <= '0;
            reg_wr_data  <= '0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            reg_wr_valid <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    sh      <= '0;
                    miso_q  <= 1'b0;
                    oe_q    <= 1'b0;
                end
                CMD: if (sclk_fall) begin
                    sh      <= {sh[DATA_WIDTH-3:0], mosi_s};
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == LAST_CMD) begin
                        rw_q   <= cmd_word[CMD_WIDTH-1];
                        addr_q <= cmd_word[ADDR_WIDTH-1:0];
                        miso_q <= 1'b0;
                        oe_q   <= 1'b0;
                        tx_shift <= (cmd_word[ADDR_WIDTH-1:0] == '0) ? ID_VALUE
                                                                   : regs[cmd_word[ADDR_WIDTH-1:0]];
                    end
                end
                DATA: begin
                    if (sclk_fall) begin
                        sh      <= {sh[DATA_WIDTH-3:0], mosi_s};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT && rw_q == WRITE && addr_q != '0) begin
                            regs[addr_q] <= rx_word;
                            reg_wr_valid <= 1'b1;
                            reg_wr_addr  <= addr_q;
                            reg_wr_data  <= rx_word;
                        end
                    end
                    if (sclk_rise && rw_q == READ) begin
                        miso_q   <= tx_shift[DATA_WIDTH-1];
                        tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                        oe_q     <= 1'b1;
                    end
                end
                default: begin
                    miso_q <= 1'b0;
                    oe_q   <= 1'b0;
                end
            endcase
        end
    end

    // Core read port sees the pre-write value in the cycle a write commits.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n)          cfg_rdata <= '0;
        else if (cfg_addr == '0) cfg_rdata <= ID_VALUE;
        else                     cfg_rdata <= regs[cfg_addr];
    end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Bench for spi_slave_regs: bit-banged SPI master against an array model of the
// register file, directed frames from the test plan plus randomized frames.
module tb_spi_slave_regs;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic [3:0]  cfg_addr = 4'd0;
    logic        spi_miso, spi_miso_oe, reg_wr_valid;
    logic [3:0]  reg_wr_addr;
    logic [10:0] reg_wr_data, cfg_rdata;

    int checks = 0;
    int errors = 0;

    logic [10:0] mdl [16];
    int          wr_cnt = 0;
    int          oe_cnt = 0;
    logic [3:0]  last_addr = '0;
    logic [10:0] last_data = '0;
    logic [10:0] coll_old = '0, coll_new = '0;
    logic        coll_pending = 1'b0;

    spi_slave_regs dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .reg_wr_valid(reg_wr_valid), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .cfg_addr(cfg_addr), .cfg_rdata(cfg_rdata)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (reg_wr_valid) begin
            wr_cnt++;
            last_addr    = reg_wr_addr;
            last_data    = reg_wr_data;
            coll_old     = cfg_rdata;
            coll_pending = 1'b1;
        end else if (coll_pending) begin
            coll_new     = cfg_rdata;
            coll_pending = 1'b0;
        end
        if (spi_miso_oe) oe_cnt++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    function automatic logic [10:0] exp_rd(input logic [3:0] a);
        return (a == 4'd0) ? 11'h305 : mdl[a];
    endfunction

    // Master: drives mosi with the rising sclk edge, samples miso just before the fall.
    task automatic spi_frame(input logic [4:0] cmd, input logic [10:0] data, input int nbits,
                             input int rst_bit, output logic [10:0] rd, output int io_bad,
                             output logic [28:0] rst_obs);
        logic [15:0] word;
        logic        in_read, exp_oe;
        word    = {cmd, data};
        rd      = '0;
        io_bad  = 0;
        rst_obs = '1;
        in_read = cmd[4];
        spi_cs_n = 1'b0;
        wait_cyc(5);
        if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) io_bad++;
        for (int i = 0; i < nbits; i++) begin
            spi_sclk = 1'b1;
            spi_mosi = word[15-i];
            wait_cyc(5);
            if (i == rst_bit) begin
                sys_rst_n = 1'b0;
                wait_cyc(2);
                rst_obs = {spi_miso, spi_miso_oe, reg_wr_valid, reg_wr_addr, reg_wr_data, cfg_rdata};
                sys_rst_n = 1'b1;
                in_read = 1'b0;
            end
            exp_oe = in_read && i >= 5;
            if (spi_miso_oe !== exp_oe) io_bad++;
            if (!exp_oe && spi_miso !== 1'b0) io_bad++;
            if (i >= 5) rd[15-i] = spi_miso;
            spi_sclk = 1'b0;
            wait_cyc(5);
        end
        wait_cyc(4);
        if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) io_bad++;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        wait_cyc(8);
    endtask

    task automatic cfg_read(input logic [3:0] a, output logic [10:0] v);
        cfg_addr = a;
        wait_cyc(2);
        v = cfg_rdata;
    endtask

    task automatic test_reset;
        logic [10:0] v;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        sys_rst_n = 1'b0;
        wait_cyc(3);
        checks++;
        if ({spi_miso, spi_miso_oe, reg_wr_valid} !== 3'b000) begin
            errors++; $display("FAIL reset_ctl: got %b expected 000", {spi_miso, spi_miso_oe, reg_wr_valid});
        end
        checks++;
        if ({reg_wr_addr, reg_wr_data, cfg_rdata} !== 26'd0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", {reg_wr_addr, reg_wr_data, cfg_rdata});
        end
        sys_rst_n = 1'b1;
        wait_cyc(2);
        for (int a = 0; a < 16; a++) begin
            cfg_read(4'(a), v);
            checks++;
            if (v !== exp_rd(4'(a))) begin
                errors++; $display("FAIL reset_reg%0d: got %h expected %h", a, v, exp_rd(4'(a)));
            end
        end
    endtask

    // Write a frame and check pulse count/content and pad quietness.
    task automatic do_write(input string nm, input logic [3:0] a, input logic [10:0] d);
        logic [10:0] rd, v;
        logic [28:0] ro;
        int bad, w0;
        w0 = wr_cnt;
        spi_frame({1'b0, a}, d, 16, -1, rd, bad, ro);
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL %s_pads: got %0d bad samples expected 0", nm, bad); end
        checks++;
        if (wr_cnt - w0 !== ((a != 0) ? 1 : 0)) begin
            errors++; $display("FAIL %s_pulses: got %0d expected %0d", nm, wr_cnt - w0, (a != 0) ? 1 : 0);
        end
        if (a != 0) begin
            checks++;
            if (last_addr !== a || last_data !== d) begin
                errors++; $display("FAIL %s_wrport: got %h/%h expected %h/%h", nm, last_addr, last_data, a, d);
            end
            mdl[a] = d;
        end
        cfg_read(a, v);
        checks++;
        if (v !== exp_rd(a)) begin errors++; $display("FAIL %s_cfg: got %h expected %h", nm, v, exp_rd(a)); end
    endtask

    task automatic do_read(input string nm, input logic [3:0] a);
        logic [10:0] rd;
        logic [28:0] ro;
        int bad, w0;
        w0 = wr_cnt;
        spi_frame({1'b1, a}, 11'h000, 16, -1, rd, bad, ro);
        checks++;
        if (rd !== exp_rd(a)) begin errors++; $display("FAIL %s_data: got %h expected %h", nm, rd, exp_rd(a)); end
        checks++;
        if (bad !== 0 || wr_cnt !== w0) begin
            errors++; $display("FAIL %s_side: got %0d bad/%0d pulses expected 0/0", nm, bad, wr_cnt - w0);
        end
    endtask

    task automatic test_write_read;
        do_write("wr3", 4'd3, 11'h5A5);
        do_read("rd3", 4'd3);
        do_read("rd_id", 4'd0);
        do_write("wr0", 4'd0, 11'h7FF);
        do_read("rd_id2", 4'd0);
    endtask

    task automatic test_abort;
        logic [10:0] rd, v;
        logic [28:0] ro;
        int bad, w0;
        w0 = wr_cnt;
        spi_frame(5'h05, 11'h7FF, 10, -1, rd, bad, ro);
        checks++;
        if (wr_cnt !== w0 || bad !== 0) begin
            errors++; $display("FAIL abort: got %0d pulses/%0d bad expected 0/0", wr_cnt - w0, bad);
        end
        cfg_read(4'd5, v);
        checks++;
        if (v !== 11'h000) begin errors++; $display("FAIL abort_reg5: got %h expected 000", v); end
        do_write("wr5", 4'd5, 11'h123);
    endtask

    task automatic test_cs_high_idle;
        int w0, o0;
        logic [10:0] v;
        w0 = wr_cnt;
        o0 = oe_cnt;
        for (int i = 0; i < 20; i++) begin
            spi_sclk = 1'b1; spi_mosi = 1'($urandom_range(0, 1)); wait_cyc(5);
            spi_sclk = 1'b0; wait_cyc(5);
        end
        spi_mosi = 1'b0;
        checks++;
        if (wr_cnt !== w0 || oe_cnt !== o0) begin
            errors++; $display("FAIL cs_high: got %0d pulses/%0d oe expected 0/0", wr_cnt - w0, oe_cnt - o0);
        end
        cfg_read(4'd3, v);
        checks++;
        if (v !== 11'h5A5) begin errors++; $display("FAIL cs_high_reg3: got %h expected 5a5", v); end
    endtask

    task automatic test_collision;
        logic [10:0] rd, d, old;
        logic [28:0] ro;
        int bad;
        d   = 11'($urandom) ^ 11'h400;
        old = mdl[7];
        cfg_addr = 4'd7;
        spi_frame(5'h07, d, 16, -1, rd, bad, ro);
        mdl[7] = d;
        checks++;
        if (coll_old !== old || coll_new !== d) begin
            errors++; $display("FAIL collision: got %h->%h expected %h->%h", coll_old, coll_new, old, d);
        end
    endtask

    task automatic test_reset_midframe;
        logic [10:0] rd, v;
        logic [28:0] ro;
        int bad, w0;
        w0 = wr_cnt;
        spi_frame(5'h03, 11'h2AA, 16, 8, rd, bad, ro);
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        checks++;
        if (ro !== 29'd0) begin errors++; $display("FAIL rst_mid_outs: got %h expected 0", ro); end
        checks++;
        if (wr_cnt !== w0 || bad !== 0) begin
            errors++; $display("FAIL rst_mid_frame: got %0d pulses/%0d bad expected 0/0", wr_cnt - w0, bad);
        end
        cfg_read(4'd3, v);
        checks++;
        if (v !== 11'h000) begin errors++; $display("FAIL rst_mid_reg3: got %h expected 000", v); end
        do_write("post_rst", 4'd10, 11'h4C3);
        do_read("post_rst_rd", 4'd10);
    endtask

    task automatic test_random;
        logic [3:0]  a;
        logic [10:0] d, v;
        for (int n = 0; n < 24; n++) begin
            a = 4'($urandom_range(0, 15));
            d = 11'($urandom);
            if ($urandom_range(0, 1) == 1) do_read("rnd_rd", a);
            else                           do_write("rnd_wr", a, d);
        end
        for (int i = 0; i < 16; i++) begin
            cfg_read(4'(i), v);
            checks++;
            if (v !== exp_rd(4'(i))) begin
                errors++; $display("FAIL final_reg%0d: got %h expected %h", i, v, exp_rd(4'(i)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_abort();
        test_cs_high_idle();
        test_collision();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/spi_slave_regs.md
Name: spi_slave_regs

Overview:
- Synthesizable SPI slave that terminates the team's 16-bit SPI frame: a 5-bit command (1 R/W bit plus a 4-bit address) followed by 11 data bits, MSB first.
- Holds a 16 x 11-bit configuration register file. Address 0 is a read-only ID register.
- Oversamples the SPI pins in the system clock domain.
- Sits between the chip pads and the core: the core gets a write-notify strobe and a registered read port.

Parameters:
- CMD_WIDTH, 5, command bits per frame (bit 4 = R/W, bits 3:0 = address).
- ADDR_WIDTH, 4, address bits.
- DATA_WIDTH, 11, data bits per frame and register width.
- WRITE, 0, R/W bit value for a write.
- READ, 1, R/W bit value for a read.
- ID_VALUE, 11'h305, read-only contents of address 0.

Ports:
- sys_clk  input  1  system clock; frequency must be at least 100 MHz (10x the SPI bit rate).
- sys_rst_n  input  1  synchronous active-low reset.
- spi_cs_n  input  1  chip select, active low, asynchronous to sys_clk.
- spi_sclk  input  1  serial clock, idles low, asynchronous to sys_clk.
- spi_mosi  input  1  master-out data; slave samples it on the sclk falling edge.
- spi_miso  output  1  slave-out data; slave updates it on the sclk rising edge.
- spi_miso_oe  output  1  miso pad output enable; high only during the data phase of a read.
- reg_wr_valid  output  1  one-cycle pulse when a register write commits.
- reg_wr_addr  output  ADDR_WIDTH  address of the committed write.
- reg_wr_data  output  DATA_WIDTH  data of the committed write.
- cfg_addr  input  ADDR_WIDTH  core-side read address.
- cfg_rdata  output  DATA_WIDTH  contents of reg[cfg_addr], registered (1-cycle latency).

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-low. Ports are named sys_clk / sys_rst_n.
- Input synchronization:
  - cs_n, sclk and mosi each pass through 2-FF synchronizers.
  - Edge detect on synced sclk produces sclk_rise / sclk_fall single-cycle strobes.
  - Edges are ignored while synced cs_n is high.
  - Worst-case latency from pin edge to strobe is 3 sys_clk cycles.
- Reset values:
  - spi_miso=0, spi_miso_oe=0, reg_wr_valid=0, reg_wr_addr=0, reg_wr_data=0, cfg_rdata=0.
  - All registers 1..15 = 0. FSM = IDLE. bit_cnt = 0.
- FSM states:
  - IDLE: bit_cnt=0 and the shift register is cleared. On synced cs_n falling go to CMD.
  - CMD: each sclk_fall shifts mosi into the shift register and increments bit_cnt. On the 5th fall, latch rw and addr and go to DATA. If rw==READ, load tx_shift with reg[addr] (ID_VALUE when addr=0).
  - DATA (read):
    - On each sclk_rise, drive spi_miso = tx_shift MSB, then shift left; assert spi_miso_oe.
    - The first rise in DATA presents bit 10.
    - On each sclk_fall, bit_cnt increments. On the 16th fall go to DONE.
  - DATA (write): each sclk_fall shifts mosi into rx_data. On the 16th fall:
    - addr!=0: write reg[addr]=rx_data and pulse reg_wr_valid for 1 cycle with addr/data. Go to DONE.
    - addr==0: no write and no pulse. Go to DONE.
  - DONE: further sclk edges are ignored; spi_miso=0, spi_miso_oe=0. On synced cs_n high go to IDLE.
- spi_miso is 0 at all times outside the DATA-read state.
- Abort: cs_n rising in CMD or DATA returns the FSM to IDLE next cycle with no write and no pulse; miso and oe go to 0.
- cs_n held high through IDLE: no state change, no output activity.
- Reset asserted mid-frame overrides everything:
  - All state returns to reset values, including register contents.
  - The remainder of the frame is ignored until cs_n goes high and then low again.
- Read/write collision: a core read of an address in the same cycle as its SPI write returns the old value. The new value appears on the next cycle.
- A back-to-back frame requires cs_n high for at least 3 sys_clk cycles; the master's 400 ns cs_n-high time satisfies this.

Test Plan:
- Write frame, cmd 5'h03 plus data 11'h5A5 -> reg_wr_valid pulses once with addr=3, data=11'h5A5; afterwards cfg_addr=3 gives cfg_rdata=11'h5A5; miso=0 and oe=0 throughout the frame.
- Read frame, cmd 5'h13 after the above write -> the master captures 11'h5A5 on miso; oe is high only during the 11 data bits; no reg_wr_valid.
- Read ID, cmd 5'h10 -> master captures 11'h305.
- Write to address 0, cmd 5'h00 with data 11'h7FF -> no reg_wr_valid; a following read of address 0 still returns 11'h305.
- Abort: cmd 5'h05 plus 5 data bits, then cs_n raised -> no pulse and reg[5] unchanged (0). A following full write of 11'h123 to address 5 commits correctly.
- Reset mid-frame: sys_rst_n low for 2 cycles during the data phase of a write to address 3 -> all outputs return to 0, reg[3] reads 0, no pulse for that frame, and the next full frame works.
